// File: rtl/hash_min_scanner.sv
// hash_min_scanner
//   Takes one array of SIZE hashes plus the matching kmers. It walks the array
//   one entry per clock and reports the smallest hash, its index and its kmer.
//   That result is one MinHash sketch element. Only one array is in flight at
//   a time.
//
// Ports
//   clk          clock, every register updates on posedge
//   rstN         synchronous reset, active high (reset when 1)
//   inValid      hashResults/kmers are valid
//   inReady      block can accept a new array (registered)
//   hashResults  SIZE x WIDTH hashes, packed [SIZE-1:0][WIDTH-1:0]
//   kmers        SIZE x WIDTH kmers, same indexing as hashResults
//   outValid     result valid (registered)
//   outReady     downstream accepts the result
//   minHash      minimum hash value
//   minIndex     index of the minimum, lowest index on ties
//   minKmer      kmers[minIndex]
//   sketchCount  number of completed output handshakes, wraps
//
// state | meaning
// IDLE  | inReady high, waiting for an array
// SCAN  | comparing stored entry idx against the running best, one per clock
// DONE  | result presented, waiting for outReady

module hash_min_scanner #(
  parameter int SIZE  = 49,
  parameter int WIDTH = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        inValid,
  output logic                        inReady,
  input  logic [SIZE-1:0][WIDTH-1:0]  hashResults,
  input  logic [SIZE-1:0][WIDTH-1:0]  kmers,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [WIDTH-1:0]            minHash,
  output logic [IDX_W-1:0]            minIndex,
  output logic [WIDTH-1:0]            minKmer,
  output logic [CNT_W-1:0]            sketchCount
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  state_t state_q, state_d;

  // Local copy of the arrays, so the producer may change its inputs
  // as soon as the array has been accepted.
  logic [SIZE-1:0][WIDTH-1:0] hash_q, kmer_q;
  logic                       capture;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [WIDTH-1:0] best_kmer_q, best_kmer_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] min_hash_q, min_hash_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;
  logic [WIDTH-1:0] min_kmer_q, min_kmer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The best value after this edge's compare. Strict less-than keeps the
  // earlier index on ties.
  logic             take;
  logic [WIDTH-1:0] cur_best;
  logic [IDX_W-1:0] cur_best_idx;
  logic [WIDTH-1:0] cur_best_kmer;

  always_comb begin
    take          = (hash_q[idx_q] < best_q);
    cur_best      = take ? hash_q[idx_q] : best_q;
    cur_best_idx  = take ? idx_q         : best_idx_q;
    cur_best_kmer = take ? kmer_q[idx_q] : best_kmer_q;
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      best_kmer_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      min_hash_q  <= '0;
      min_idx_q   <= '0;
      min_kmer_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      best_kmer_q <= best_kmer_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      min_hash_q  <= min_hash_d;
      min_idx_q   <= min_idx_d;
      min_kmer_q  <= min_kmer_d;
      cnt_q       <= cnt_d;
    end
  end

  // The storage has no reset. Its contents matter only after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      hash_q <= hashResults;
      kmer_q <= kmers;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    best_kmer_d = best_kmer_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    min_hash_d  = min_hash_q;
    min_idx_d   = min_idx_q;
    min_kmer_d  = min_kmer_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        if (inValid && in_ready_q) begin
          capture     = 1'b1;
          best_d      = hashResults[0];
          best_idx_d  = '0;
          best_kmer_d = kmers[0];
          in_ready_d  = 1'b0;
          if (SIZE == 1) begin
            // Entry 0 is the only candidate, so the result is ready now.
            idx_d       = '0;
            min_hash_d  = hashResults[0];
            min_idx_d   = '0;
            min_kmer_d  = kmers[0];
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        best_d      = cur_best;
        best_idx_d  = cur_best_idx;
        best_kmer_d = cur_best_kmer;
        if (idx_q == LAST_IDX) begin
          min_hash_d  = cur_best;
          min_idx_d   = cur_best_idx;
          min_kmer_d  = cur_best_kmer;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_valid_q && outReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign inReady     = in_ready_q;
  assign outValid    = out_valid_q;
  assign minHash     = min_hash_q;
  assign minIndex    = min_idx_q;
  assign minKmer     = min_kmer_q;
  assign sketchCount = cnt_q;

endmodule

// File: tb/tb_hash_min_scanner.sv
module tb_hash_min_scanner;

  localparam int SIZE  = 49;
  localparam int WIDTH = 32;
  localparam int IDX_W = 6;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rstN;
  logic inValid;
  logic outReady;
  logic [SIZE-1:0][WIDTH-1:0] hashResults;
  logic [SIZE-1:0][WIDTH-1:0] kmers;

  logic             inReady, outValid;
  logic [WIDTH-1:0] minHash, minKmer;
  logic [IDX_W-1:0] minIndex;
  logic [CNT_W-1:0] sketchCount;

  // Second instance with a 2-bit counter on the same inputs, for the wrap check.
  logic             w_inReady, w_outValid;
  logic [WIDTH-1:0] w_minHash, w_minKmer;
  logic [IDX_W-1:0] w_minIndex;
  logic [1:0]       w_sketchCount;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  hash_min_scanner #(.SIZE(SIZE), .WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .hashResults(hashResults), .kmers(kmers),
    .outValid(outValid), .outReady(outReady),
    .minHash(minHash), .minIndex(minIndex), .minKmer(minKmer),
    .sketchCount(sketchCount)
  );

  hash_min_scanner #(.SIZE(SIZE), .WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(2)) dut_w (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(w_inReady),
    .hashResults(hashResults), .kmers(kmers),
    .outValid(w_outValid), .outReady(outReady),
    .minHash(w_minHash), .minIndex(w_minIndex), .minKmer(w_minKmer),
    .sketchCount(w_sketchCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present the array for one edge, then wait for outValid. lat counts the
  // edges after the accept edge, and ends at 200 on timeout.
  task automatic send(output int lat);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b1; inValid = 1'b0; outReady = 1'b0;
    hashResults = '0; kmers = '0;
    tick(); tick();
    rstN = 1'b0;
    exp_cnt = 0;
    n_checks += 6;
    if (inReady !== 1'b1) begin n_fail++; $display("FAIL reset_inReady got %0b want 1", inReady); end
    if (outValid !== 1'b0) begin n_fail++; $display("FAIL reset_outValid got %0b want 0", outValid); end
    if (minHash !== 32'h0) begin n_fail++; $display("FAIL reset_minHash got %h want 0", minHash); end
    if (minIndex !== 6'd0) begin n_fail++; $display("FAIL reset_minIndex got %0d want 0", minIndex); end
    if (minKmer !== 32'h0) begin n_fail++; $display("FAIL reset_minKmer got %h want 0", minKmer); end
    if (sketchCount !== 16'd0) begin n_fail++; $display("FAIL reset_sketchCount got %0d want 0", sketchCount); end
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'(i + 10);
      kmers[i]       = 32'(32'h1000 + i);
    end
    outReady = 1'b1;
    send(lat);
    n_checks += 5;
    if (lat !== 48) begin n_fail++; $display("FAIL basic_latency got %0d want 48", lat); end
    if (minHash !== 32'd10) begin n_fail++; $display("FAIL basic_minHash got %0d want 10", minHash); end
    if (minIndex !== 6'd0) begin n_fail++; $display("FAIL basic_minIndex got %0d want 0", minIndex); end
    if (minKmer !== 32'h1000) begin n_fail++; $display("FAIL basic_minKmer got %h want 1000", minKmer); end
    if (inReady !== 1'b0) begin n_fail++; $display("FAIL basic_inReady_busy got %0b want 0", inReady); end
    tick();
    exp_cnt++;
    n_checks += 3;
    if (outValid !== 1'b0) begin n_fail++; $display("FAIL basic_outValid_pulse got %0b want 0", outValid); end
    if (sketchCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL basic_sketchCount got %0d want %0d", sketchCount, exp_cnt); end
    if (inReady !== 1'b1) begin n_fail++; $display("FAIL basic_inReady_after got %0b want 1", inReady); end
  endtask

  task automatic test_last_entry();
    int lat;
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'd200;
      kmers[i]       = 32'(i);
    end
    hashResults[48] = 32'd3;
    kmers[48]       = 32'hABCD;
    send(lat);
    n_checks += 4;
    if (lat !== 48) begin n_fail++; $display("FAIL last_latency got %0d want 48", lat); end
    if (minHash !== 32'd3) begin n_fail++; $display("FAIL last_minHash got %0d want 3", minHash); end
    if (minIndex !== 6'd48) begin n_fail++; $display("FAIL last_minIndex got %0d want 48", minIndex); end
    if (minKmer !== 32'hABCD) begin n_fail++; $display("FAIL last_minKmer got %h want abcd", minKmer); end
    tick();
    exp_cnt++;
    n_checks++;
    if (sketchCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL last_sketchCount got %0d want %0d", sketchCount, exp_cnt); end
  endtask

  task automatic test_ties();
    int lat;
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'd254;
      kmers[i]       = 32'(32'h500 + i);
    end
    hashResults[30] = 32'd5;
    hashResults[40] = 32'd5;
    send(lat);
    n_checks += 3;
    if (minHash !== 32'd5) begin n_fail++; $display("FAIL tie_minHash got %0d want 5", minHash); end
    if (minIndex !== 6'd30) begin n_fail++; $display("FAIL tie_minIndex got %0d want 30", minIndex); end
    if (minKmer !== 32'h51E) begin n_fail++; $display("FAIL tie_minKmer got %h want 51e", minKmer); end
    tick();
    exp_cnt++;
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'hFFFF_FFFF;
      kmers[i]       = 32'(32'h7000 + i);
    end
    send(lat);
    n_checks += 4;
    if (lat !== 48) begin n_fail++; $display("FAIL allones_latency got %0d want 48", lat); end
    if (minHash !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL allones_minHash got %h want ffffffff", minHash); end
    if (minIndex !== 6'd0) begin n_fail++; $display("FAIL allones_minIndex got %0d want 0", minIndex); end
    if (minKmer !== 32'h7000) begin n_fail++; $display("FAIL allones_minKmer got %h want 7000", minKmer); end
    tick();
    exp_cnt++;
    n_checks++;
    if (sketchCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ties_sketchCount got %0d want %0d", sketchCount, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int lat;
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'(1000 - 3 * i);
      kmers[i]       = 32'(32'h2000 + i);
    end
    outReady = 1'b0;
    send(lat);
    n_checks += 3;
    if (lat !== 48) begin n_fail++; $display("FAIL bp_latency got %0d want 48", lat); end
    if (minHash !== 32'd856) begin n_fail++; $display("FAIL bp_minHash got %0d want 856", minHash); end
    if (minKmer !== 32'h2030) begin n_fail++; $display("FAIL bp_minKmer got %h want 2030", minKmer); end
    // A new array is offered while the result is stalled.
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'd7;
      kmers[i]       = 32'(32'h3000 + i);
    end
    inValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks += 5;
      if (outValid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_outValid cyc %0d got %0b want 1", c, outValid); end
      if (inReady !== 1'b0) begin n_fail++; $display("FAIL bp_hold_inReady cyc %0d got %0b want 0", c, inReady); end
      if (minHash !== 32'd856) begin n_fail++; $display("FAIL bp_hold_minHash cyc %0d got %0d want 856", c, minHash); end
      if (minIndex !== 6'd48) begin n_fail++; $display("FAIL bp_hold_minIndex cyc %0d got %0d want 48", c, minIndex); end
      if (minKmer !== 32'h2030) begin n_fail++; $display("FAIL bp_hold_minKmer cyc %0d got %h want 2030", c, minKmer); end
    end
    outReady = 1'b1;
    tick();
    exp_cnt++;
    n_checks += 4;
    if (outValid !== 1'b0) begin n_fail++; $display("FAIL bp_hs_outValid got %0b want 0", outValid); end
    if (inReady !== 1'b1) begin n_fail++; $display("FAIL bp_hs_inReady got %0b want 1", inReady); end
    if (minHash !== 32'd856) begin n_fail++; $display("FAIL bp_hs_retain got %0d want 856", minHash); end
    if (sketchCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL bp_hs_sketchCount got %0d want %0d", sketchCount, exp_cnt); end
    // inValid is still high, so the held array is accepted at the next edge.
    send(lat);
    n_checks += 4;
    if (lat !== 48) begin n_fail++; $display("FAIL bp_next_latency got %0d want 48", lat); end
    if (minHash !== 32'd7) begin n_fail++; $display("FAIL bp_next_minHash got %0d want 7", minHash); end
    if (minIndex !== 6'd0) begin n_fail++; $display("FAIL bp_next_minIndex got %0d want 0", minIndex); end
    if (minKmer !== 32'h3000) begin n_fail++; $display("FAIL bp_next_minKmer got %h want 3000", minKmer); end
    tick();
    exp_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'(500 + i);
      kmers[i]       = 32'(32'h6000 + i);
    end
    outReady = 1'b1;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    rstN = 1'b1;
    tick();
    rstN = 1'b0;
    exp_cnt = 0;
    n_checks += 7;
    if (outValid !== 1'b0) begin n_fail++; $display("FAIL rmid_outValid got %0b want 0", outValid); end
    if (inReady !== 1'b1) begin n_fail++; $display("FAIL rmid_inReady got %0b want 1", inReady); end
    if (minHash !== 32'h0) begin n_fail++; $display("FAIL rmid_minHash got %h want 0", minHash); end
    if (minIndex !== 6'd0) begin n_fail++; $display("FAIL rmid_minIndex got %0d want 0", minIndex); end
    if (minKmer !== 32'h0) begin n_fail++; $display("FAIL rmid_minKmer got %h want 0", minKmer); end
    if (sketchCount !== 16'd0) begin n_fail++; $display("FAIL rmid_sketchCount got %0d want 0", sketchCount); end
    if (w_sketchCount !== 2'd0) begin n_fail++; $display("FAIL rmid_w_sketchCount got %0d want 0", w_sketchCount); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (outValid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rmid_no_output got %0d valid cycles want 0", seen); end
    for (int i = 0; i < SIZE; i++) begin
      hashResults[i] = 32'(100 + i);
      kmers[i]       = 32'(32'h4000 + i);
    end
    hashResults[7] = 32'd1;
    send(lat);
    n_checks += 4;
    if (lat !== 48) begin n_fail++; $display("FAIL rmid_next_latency got %0d want 48", lat); end
    if (minHash !== 32'd1) begin n_fail++; $display("FAIL rmid_next_minHash got %0d want 1", minHash); end
    if (minIndex !== 6'd7) begin n_fail++; $display("FAIL rmid_next_minIndex got %0d want 7", minIndex); end
    if (minKmer !== 32'h4007) begin n_fail++; $display("FAIL rmid_next_minKmer got %h want 4007", minKmer); end
    tick();
    exp_cnt++;
    n_checks++;
    if (sketchCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rmid_next_sketchCount got %0d want %0d", sketchCount, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [1:0] wrap_seq [5];
    wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
    wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;
    rstN = 1'b1;
    tick();
    rstN = 1'b0;
    exp_cnt = 0;
    outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < SIZE; i++) begin
        hashResults[i] = 32'(50 + i);
        kmers[i]       = 32'(32'h9000 + 16 * k + i);
      end
      hashResults[5 * k + 3] = 32'(k);
      send(lat);
      n_checks += 6;
      if (lat !== 48) begin n_fail++; $display("FAIL b2b_latency seq %0d got %0d want 48", k, lat); end
      if (minHash !== 32'(k)) begin n_fail++; $display("FAIL b2b_minHash seq %0d got %0d want %0d", k, minHash, k); end
      if (minIndex !== 6'(5 * k + 3)) begin n_fail++; $display("FAIL b2b_minIndex seq %0d got %0d want %0d", k, minIndex, 5 * k + 3); end
      if (w_outValid !== 1'b1 || w_minHash !== minHash) begin n_fail++; $display("FAIL b2b_w_result seq %0d got v=%0b h=%0d want v=1 h=%0d", k, w_outValid, w_minHash, k); end
      if (w_minIndex !== 6'(5 * k + 3)) begin n_fail++; $display("FAIL b2b_w_minIndex seq %0d got %0d want %0d", k, w_minIndex, 5 * k + 3); end
      if (w_minKmer !== 32'(32'h9000 + 16 * k + 5 * k + 3)) begin n_fail++; $display("FAIL b2b_w_minKmer seq %0d got %h", k, w_minKmer); end
      tick();
      exp_cnt++;
      n_checks += 3;
      if (w_sketchCount !== wrap_seq[k]) begin n_fail++; $display("FAIL wrap_sketchCount seq %0d got %0d want %0d", k, w_sketchCount, wrap_seq[k]); end
      if (sketchCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL b2b_sketchCount seq %0d got %0d want %0d", k, sketchCount, exp_cnt); end
      if (w_inReady !== 1'b1) begin n_fail++; $display("FAIL b2b_w_inReady seq %0d got %0b want 1", k, w_inReady); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_entry();
    test_ties();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
